// File: rtl/correlator_readout_pkg.sv
// Shared constants and types for the correlator readout sequencer.
// Provides the bank map, per-bank length table, header tag default,
// FSM state encoding and the output-buffer beat payload.
package correlator_readout_pkg;

    localparam int unsigned NUM_BANKS   = 5;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned BANK_W      = 4;
    localparam int unsigned IDX_W       = 9;
    localparam int unsigned LEN_W       = 10;
    localparam int unsigned FRAME_CNT_W = 16;

    localparam logic [15:0]       HDR_TAG_DEFAULT = 16'hA5A5;
    localparam logic [BANK_W-1:0] FIRST_BANK      = 4'd1;
    localparam logic [BANK_W-1:0] LAST_BANK       = 4'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HEAD  = 3'd1,
        ST_SCAN  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // One buffered stream beat: data word plus end-of-frame sideband.
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;

    // Number of result words held in each bank (bank base nibble 1..5).
    function automatic logic [LEN_W-1:0] bank_len(input logic [BANK_W-1:0] bank);
        logic [LEN_W-1:0] len;
        case (bank)
            4'd1:    len = 10'd32;
            4'd2:    len = 10'd64;
            4'd3:    len = 10'd128;
            4'd4:    len = 10'd256;
            default: len = 10'd512;
        endcase
        return len;
    endfunction

    // Highest index within a bank.
    function automatic logic [IDX_W-1:0] bank_last_idx(input logic [BANK_W-1:0] bank);
        return IDX_W'(bank_len(bank) - 10'd1);
    endfunction

endpackage

// File: rtl/readout_fifo.sv
// Small synchronous FIFO used as the readout output buffer.
// Ports: clk, rst_n (async active-low), push_i/push_data_i write side,
// pop_i/pop_data_o read side (first-word fall-through), count_o occupancy,
// empty_o/full_o flags. Push while full is accepted only with a same-cycle pop.
module readout_fifo #(
    parameter  int unsigned WIDTH = 33,
    parameter  int unsigned DEPTH = 3,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push_c;
    logic             do_pop_c;

    // Pointer increment with wrap for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop_c  = pop_i && (count_q != '0);
    assign do_push_c = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop_c);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_c) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop_c) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            count_q <= count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/correlator_readout.sv
// Correlator readout sequencer: on Start, sweeps the RAM read address over
// banks 1..5, captures RamData after the read latency and streams a framed
// burst (header + 992 data words) over OutValid/OutReady.
// Ports: clk, rst_n (async active-low); Start request; Busy/Freeze while a
// frame is in progress; Done pulse after the last handshake; RamAddr/RamData
// to the RAM read mux; OutData/OutValid/OutReady/OutLast stream.
module correlator_readout
    import correlator_readout_pkg::*;
#(
    parameter int unsigned RD_LAT  = 1,
    parameter logic [15:0] HDR_TAG = HDR_TAG_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Start,
    output logic              Busy,
    output logic              Done,
    output logic              Freeze,
    output logic [ADDR_W-1:0] RamAddr,
    input  logic [DATA_W-1:0] RamData,
    output logic [DATA_W-1:0] OutData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              OutLast
);

    localparam int unsigned FIFO_DEPTH = RD_LAT + 2;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    // Stage 0 lines up with the RamAddr register; the word is sampled one
    // cycle after the RAM presents it, hence RD_LAT + 1 stages.
    localparam int unsigned PIPE_D     = RD_LAT + 1;
    localparam int unsigned CRED_W     = 8;
    localparam int unsigned BEAT_W     = $bits(beat_t);

    state_e                 state_q, state_d;
    logic [BANK_W-1:0]      bank_q, bank_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [ADDR_W-1:0]      ram_addr_q, ram_addr_d;
    logic [PIPE_D-1:0]      tag_q, tag_d;
    logic [PIPE_D-1:0]      last_q, last_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   push_c;
    logic                   pop_c;
    beat_t                  push_beat_c;
    beat_t                  head_beat;
    logic [BEAT_W-1:0]      head_raw;

    logic                   hdr_c;
    logic                   scanning_c;
    logic                   issue_c;
    logic                   last_addr_c;
    logic                   credit_ok_c;
    logic [CRED_W-1:0]      inflight_c;
    logic [CRED_W-1:0]      used_c;

    readout_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_c),
        .push_data_i (push_beat_c),
        .pop_i       (pop_c),
        .pop_data_o  (head_raw),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    assign head_beat = beat_t'(head_raw);

    // Credit accounting: every issued read, buffered word and the header
    // owns one buffer slot. The slot freed by a same-cycle pop is reusable,
    // which is what sustains one word per clock with OutReady high.
    always_comb begin
        inflight_c = '0;
        for (int unsigned i = 0; i < PIPE_D; i++) begin
            inflight_c = inflight_c + CRED_W'(tag_q[i]);
        end
        pop_c       = !fifo_empty && OutReady;
        hdr_c       = (state_q == ST_HEAD);
        scanning_c  = (state_q == ST_HEAD) || (state_q == ST_SCAN);
        used_c      = inflight_c + CRED_W'(fifo_count) + CRED_W'(hdr_c);
        credit_ok_c = (used_c < (CRED_W'(FIFO_DEPTH) + CRED_W'(pop_c)))
                      && !(fifo_full && !pop_c);
        issue_c     = scanning_c && credit_ok_c;
        last_addr_c = (bank_q == LAST_BANK) && (idx_q == bank_last_idx(bank_q));
    end

    // Buffer write: header in HEAD, otherwise RAM word when its tag emerges.
    always_comb begin
        push_c      = 1'b0;
        push_beat_c = '0;
        if (hdr_c) begin
            push_c      = 1'b1;
            push_beat_c = '{last: 1'b0, data: {HDR_TAG, frame_cnt_q}};
        end else if (tag_q[PIPE_D-1]) begin
            push_c      = 1'b1;
            push_beat_c = '{last: last_q[PIPE_D-1], data: RamData};
        end
    end

    // Next-state: FSM, address walk, read-tag pipeline.
    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        idx_d       = idx_q;
        ram_addr_d  = ram_addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        tag_d       = {tag_q[PIPE_D-2:0], issue_c};
        last_d      = {last_q[PIPE_D-2:0], issue_c && last_addr_c};

        if (issue_c) begin
            ram_addr_d = {bank_q, 3'b000, idx_q};
            if (idx_q == bank_last_idx(bank_q)) begin
                bank_d = bank_q + BANK_W'(1);
                idx_d  = '0;
            end else begin
                idx_d  = idx_q + IDX_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_HEAD;
                    busy_d  = 1'b1;
                    bank_d  = FIRST_BANK;
                    idx_d   = '0;
                end
            end
            ST_HEAD: begin
                state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (issue_c && last_addr_c) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop_c && head_beat.last && (fifo_count == CNT_W'(1))
                    && (tag_q == '0)) begin
                    state_d    = ST_DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    ram_addr_d = '0;
                end
            end
            ST_DONE: begin
                frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bank_q      <= FIRST_BANK;
            idx_q       <= '0;
            ram_addr_q  <= '0;
            tag_q       <= '0;
            last_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            idx_q       <= idx_d;
            ram_addr_q  <= ram_addr_d;
            tag_q       <= tag_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign Busy     = busy_q;
    assign Freeze   = busy_q;
    assign Done     = done_q;
    assign RamAddr  = ram_addr_q;
    assign OutValid = !fifo_empty;
    assign OutData  = head_beat.data;
    assign OutLast  = head_beat.last && !fifo_empty;

endmodule
